// File: rtl/rr_arb4_onehot.sv
// Four-way round-robin arbiter with a registered one-hot grant and a hold-time limit.
// A grant is released on done, on the holder dropping its request, or when MAX_HOLD expires.
module rr_arb4_onehot #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] win_q, win_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic       timeout_q, timeout_d;

  logic [1:0] win_sel;
  logic [1:0] idx;
  logic       found;
  logic       expire;
  logic       holder_req;
  logic       release_now;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win_sel = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win_sel = idx;
        found   = 1'b1;
      end
    end
  end

  assign expire      = (cnt_q == HoldLast);
  assign holder_req  = req[win_q];
  assign release_now = done || !holder_req || expire;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_vld_d = gnt_vld_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d   = StBusy;
          win_d     = win_sel;
          cnt_d     = '0;
          gnt_d     = 4'b0001 << win_sel;
          gnt_vld_d = 1'b1;
        end
      end
      StBusy: begin
        if (release_now) begin
          state_d   = StIdle;
          ptr_d     = win_q + 2'd1;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          // Only a pure expiry counts as a timeout; done takes precedence.
          timeout_d = expire && !done && holder_req;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_vld_q <= gnt_vld_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb4_onehot.sv
// Directed bench for rr_arb4_onehot: round-robin order, expiry, wrap, release on request drop,
// done/expiry collision, asynchronous reset mid-grant and a MAX_HOLD = 1 instance.
module tb_rr_arb4_onehot;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic       timeout;
  logic [3:0] gnt1;
  logic       gnt_vld1;
  logic       timeout1;

  int n_cmp  = 0;
  int n_fail = 0;

  rr_arb4_onehot #(.MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  rr_arb4_onehot #(.MAX_HOLD(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt1),
    .gnt_vld (gnt_vld1),
    .timeout (timeout1)
  );

  always #5 clk = ~clk;

  property p_gnt_shape;
    @(negedge clk) disable iff (rst) $onehot0(gnt) && (gnt_vld == |gnt);
  endproperty
  a_gnt_shape: assert property (p_gnt_shape);

  property p_gnt1_shape;
    @(negedge clk) disable iff (rst) $onehot0(gnt1) && (gnt_vld1 == |gnt1);
  endproperty
  a_gnt1_shape: assert property (p_gnt1_shape);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt);
    end
    n_cmp++;
    if (gnt_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt_vld: got %b want 0", gnt_vld);
    end
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000) begin
      n_fail++; $display("FAIL idle_no_req: got %b want 0000", gnt);
    end
  endtask

  // V1: all four requesting, done one cycle after each grant.
  task automatic test_round_robin();
    logic [3:0] exp_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++;
      if (gnt !== exp_seq[i] || gnt_vld !== (exp_seq[i] != 4'b0000)) begin
        n_fail++;
        $display("FAIL rr_seq[%0d]: got gnt=%b vld=%b want gnt=%b", i, gnt, gnt_vld, exp_seq[i]);
      end
      done = (exp_seq[i] != 4'b0000);
    end
    req = 4'b0000;
    tick();
    done = 1'b0;
    tick();
  endtask

  // V2: lone requester held past MAX_HOLD = 8.
  task automatic test_timeout();
    req = 4'b0100;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (gnt !== 4'b0100 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got gnt=%b to=%b want gnt=0100 to=0", i, gnt, timeout);
      end
      tick();
    end
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_fail++; $display("FAIL expiry: got gnt=%b to=%b want gnt=0000 to=1", gnt, timeout);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL regrant: got gnt=%b to=%b want gnt=0100 to=0", gnt, timeout);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL done_release: got gnt=%b to=%b want gnt=0000 to=0", gnt, timeout);
    end
  endtask

  // V3: ptr sits at 3, requesters 0 and 1 -> wrap to 0 then 1.
  task automatic test_wrap();
    req = 4'b0011;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_first: got %b want 0001", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL wrap_second: got %b want 0010", gnt);
    end
    done = 1'b1;
    req  = 4'b0000;
    tick();
    done = 1'b0;
  endtask

  // V4: holder 1 drops its request while 3 waits; 3 must not pre-empt.
  task automatic test_req_drop();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL drop_grant: got %b want 0010", gnt);
    end
    req = 4'b1010;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL no_preempt: got %b want 0010", gnt);
    end
    req = 4'b1000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL drop_release: got gnt=%b to=%b want gnt=0000 to=0", gnt, timeout);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_fail++; $display("FAIL drop_next: got %b want 1000", gnt);
    end
    req  = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // V5: done coincides with the expiry edge; also done in IDLE is ignored.
  task automatic test_done_on_expiry();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 7; i++) tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL pre_expiry: got %b want 0001", gnt);
    end
    done = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL done_wins: got gnt=%b to=%b want gnt=0000 to=0", gnt, timeout);
    end
    req = 4'b0000;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      n_fail++; $display("FAIL idle_done: got gnt=%b vld=%b want gnt=0000 vld=0", gnt, gnt_vld);
    end
    done = 1'b0;
  endtask

  // V6: asynchronous reset between edges while requester 2 holds the grant.
  task automatic test_reset_mid_grant();
    req = 4'b0100;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_fail++; $display("FAIL v6_grant: got %b want 0100", gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got gnt=%b vld=%b to=%b want 0000/0/0", gnt, gnt_vld, timeout);
    end
    req = 4'b1000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL rst_held: got gnt=%b to=%b want gnt=0000 to=0", gnt, timeout);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_fail++; $display("FAIL post_rst_grant: got %b want 1000", gnt);
    end
    done = 1'b1;
    req  = 4'b1001;
    tick();
    done = 1'b0;
    tick();
    // ptr advanced past 3 -> 0, so requester 0 wins over 3.
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL post_rst_wrap: got %b want 0001", gnt);
    end
    req  = 4'b0000;
    tick();
    tick();
  endtask

  // MAX_HOLD = 1: each grant lasts one cycle and expires with a timeout pulse.
  task automatic test_max_hold1();
    req = 4'b0010;
    tick();
    n_cmp++;
    if (gnt1 !== 4'b0010) begin
      n_fail++; $display("FAIL mh1_grant: got %b want 0010", gnt1);
    end
    tick();
    n_cmp++;
    if (gnt1 !== 4'b0000 || timeout1 !== 1'b1) begin
      n_fail++; $display("FAIL mh1_expire: got gnt=%b to=%b want gnt=0000 to=1", gnt1, timeout1);
    end
    tick();
    n_cmp++;
    if (gnt1 !== 4'b0010 || timeout1 !== 1'b0) begin
      n_fail++; $display("FAIL mh1_regrant: got gnt=%b to=%b want gnt=0010 to=0", gnt1, timeout1);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_wrap();
    test_req_drop();
    test_done_on_expiry();
    test_reset_mid_grant();
    test_max_hold1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
